// File: rtl/ps2_keyboard_pkg.sv
// ps2_keyboard_pkg: shared types and constants for the PS/2 keyboard controller
package ps2_keyboard_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_e;
  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } ps2_evt_t;
  localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
  localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;
endpackage

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo: first-word fall-through event FIFO.
//   clk/rst_n     clock, synchronous active-low reset
//   push/din      write request and event; dropped (drop=1) when full without a same-cycle pop
//   pop           advances the head when valid
//   dout/valid    head event (zero when empty) and non-empty flag
//   level         current occupancy
module ps2_event_fifo
  import ps2_keyboard_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  ps2_evt_t      din,
  input  logic          pop,
  output ps2_evt_t      dout,
  output logic          valid,
  output logic [LW-1:0] level,
  output logic          drop
);
  logic [AW-1:0] wr_q, rd_q;
  logic [LW-1:0] level_q;
  ps2_evt_t      mem_q [DEPTH];
  logic          full, rd_en, wr_en;
  assign valid = level_q != '0;
  assign full  = level_q == LW'(DEPTH);
  assign rd_en = pop & valid;
  assign wr_en = push & (~full | rd_en);
  assign drop  = push & full & ~rd_en;
  assign dout  = valid ? mem_q[rd_q] : '0;
  assign level = level_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_q] <= din;
        wr_q        <= wr_q + 1'b1;
      end
      if (rd_en) rd_q <= rd_q + 1'b1;
      level_q <= level_q + LW'(wr_en) - LW'(rd_en);
    end
  end
endmodule

// File: rtl/ps2_keyboard_ctrl.sv
// ps2_keyboard_ctrl: PS/2 keyboard frame receiver, scan-code decoder and event FIFO.
//   ACLK/ARESETN        clock, synchronous active-low reset
//   ps2_clk/ps2_data    raw asynchronous PS/2 lines
//   evt_pop/err_clr     head pop request, sticky error clear
//   evt_data/evt_valid  FIFO head {ext, rel, code} and non-empty flag
//   fifo_level          occupancy; overflow/frame_err sticky error flags
//   Define PS2_KBD_TIMEOUT_EN to abandon partial frames after TIMEOUT_CYCLES idle cycles.
module ps2_keyboard_ctrl
  import ps2_keyboard_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  input  logic                          evt_pop,
  input  logic                          err_clr,
  output logic [9:0]                    evt_data,
  output logic                          evt_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          frame_err
);
  ps2_state_e state_q, state_d;
  logic [1:0] clk_s_q, dat_s_q;
  logic       clk_h_q;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d;
  logic       par_q, par_d, ext_q, ext_d, rel_q, rel_d;
  logic       ovf_q, ferr_q;
  logic       sample, bit_in, push, ferr_set, drop, to_fire;
  ps2_evt_t   head;
  assign sample = clk_h_q & ~clk_s_q[1];
  assign bit_in = dat_s_q[1];
`ifdef PS2_KBD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_q;
  // Counts cycles since the last sample while a frame is open.
  assign to_fire = state_q != IDLE && !sample && to_q == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge ACLK)
    to_q <= (!ARESETN || state_q == IDLE || sample || to_fire) ? '0 : to_q + 1'b1;
`else
  assign to_fire = 1'b0;
`endif
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      clk_s_q <= '1;
      dat_s_q <= '1;
      clk_h_q <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      ext_q   <= 1'b0;
      rel_q   <= 1'b0;
      ovf_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      clk_s_q <= {clk_s_q[0], ps2_clk};
      dat_s_q <= {dat_s_q[0], ps2_data};
      clk_h_q <= clk_s_q[1];
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      ext_q   <= ext_d;
      rel_q   <= rel_d;
      ovf_q   <= drop | (ovf_q & ~err_clr);
      ferr_q  <= ferr_set | (ferr_q & ~err_clr);
    end
  end
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    par_d    = par_q;
    ext_d    = ext_q;
    rel_d    = rel_q;
    push     = 1'b0;
    ferr_set = 1'b0;
    if (sample) begin
      case (state_q)
        IDLE: begin
          state_d = bit_in ? IDLE : DATA;
          cnt_d   = '0;
        end
        DATA: begin
          sh_d    = {bit_in, sh_q[7:1]};
          cnt_d   = cnt_q + 1'b1;
          state_d = cnt_q == 3'd7 ? PARITY : DATA;
        end
        PARITY: begin
          par_d   = bit_in;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          // Prefix bytes only arm flags; every other outcome consumes them.
          if (^{sh_q, par_q} & bit_in) begin
            ext_d = sh_q == PS2_EXT_PREFIX ? 1'b1 : (sh_q == PS2_BRK_PREFIX ? ext_q : 1'b0);
            rel_d = sh_q == PS2_BRK_PREFIX ? 1'b1 : (sh_q == PS2_EXT_PREFIX ? rel_q : 1'b0);
            push  = sh_q != PS2_EXT_PREFIX && sh_q != PS2_BRK_PREFIX;
          end else begin
            ferr_set = 1'b1;
            ext_d    = 1'b0;
            rel_d    = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (to_fire) begin
      state_d = IDLE;
      ext_d   = 1'b0;
      rel_d   = 1'b0;
    end
  end
  ps2_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (ACLK),
    .rst_n (ARESETN),
    .push  (push),
    .din   ('{ext: ext_q, rel: rel_q, code: sh_q}),
    .pop   (evt_pop),
    .dout  (head),
    .valid (evt_valid),
    .level (fifo_level),
    .drop  (drop)
  );
  assign evt_data  = head;
  assign overflow  = ovf_q;
  assign frame_err = ferr_q;
endmodule
